// File: rtl/fp_exception_pipe.sv
// Two-stage IEEE-754 special-case resolver that sits in front of the add/sub datapath.
// Optional: define FP_EXC_DENORMAL_FLUSH_EN to flush denormal operands to signed zero.
module fp_exception_pipe #(
   parameter int WIDTH     = 32,
   parameter int EXP_BITS  = 8,
   parameter int MANT_BITS = 23,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             operation_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_special,
   output logic             perform_operation,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             a_is_denormal,
   output logic             b_is_denormal,
   output logic             invalid_operation,
   input  logic             flags_clr,
   output logic             sticky_invalid,
   output logic             sticky_denormal,
   output logic [CNT_W-1:0] invalid_count
);
   localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

   // Index 0 is a, index 1 is b with the effective (add/sub) sign already applied.
   logic [WIDTH-1:0] op_raw [2];
   logic [WIDTH-1:0] op_cap [2];
   logic [1:0]       nan_c, snan_c, inf_c, den_c, zero_c;

   assign op_raw[0] = a;
   assign op_raw[1] = {b[WIDTH-1] ^ ~operation_select, b[WIDTH-2:0]};

   for (genvar gi = 0; gi < 2; gi++) begin : g_class
      logic [EXP_BITS-1:0]  e;
      logic [MANT_BITS-1:0] f;
      assign e           = op_raw[gi][WIDTH-2:MANT_BITS];
      assign f           = op_raw[gi][MANT_BITS-1:0];
      assign nan_c[gi]   = (&e) & (|f);
      assign snan_c[gi]  = (&e) & (|f) & ~f[MANT_BITS-1];
      assign inf_c[gi]   = (&e) & ~(|f);
      assign den_c[gi]   = ~(|e) & (|f);
`ifdef FP_EXC_DENORMAL_FLUSH_EN
      assign zero_c[gi]  = ~(|e);
      assign op_cap[gi]  = den_c[gi] ? {op_raw[gi][WIDTH-1], {(WIDTH-1){1'b0}}} : op_raw[gi];
`else
      assign zero_c[gi]  = ~(|e) & ~(|f);
      assign op_cap[gi]  = op_raw[gi];
`endif
   end

   logic             s1_valid;
   logic [WIDTH-1:0] s1_op [2];
   logic [1:0]       s1_nan, s1_snan, s1_inf, s1_den, s1_zero;
   logic             s1_load, s1_adv, s2_load, hs;

   assign s2_load  = ~out_valid | out_ready;
   assign s1_adv   = s1_valid & s2_load;
   assign s1_load  = ~s1_valid | s1_adv;
   assign in_ready = s1_load;
   assign hs       = out_valid & out_ready;
   assign perform_operation = out_valid & ~out_special;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op[0] <= '0;
         s1_op[1] <= '0;
         s1_nan   <= '0;
         s1_snan  <= '0;
         s1_inf   <= '0;
         s1_den   <= '0;
         s1_zero  <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         s1_op[0] <= op_cap[0];
         s1_op[1] <= op_cap[1];
         s1_nan   <= nan_c;
         s1_snan  <= snan_c;
         s1_inf   <= inf_c;
         s1_den   <= den_c;
         s1_zero  <= zero_c;
      end
   end

   // Special-case resolution; first matching rule wins.
   logic             res_special, res_invalid;
   logic [WIDTH-1:0] res_result;

   always_comb begin
      res_special = 1'b1;
      res_invalid = 1'b0;
      res_result  = '0;
      if (|s1_nan) begin
         res_result  = QNAN;
         res_invalid = |s1_snan;
      end else if ((&s1_inf) && (s1_op[0][WIDTH-1] != s1_op[1][WIDTH-1])) begin
         res_result  = QNAN;
         res_invalid = 1'b1;
      end else if (s1_inf[0]) begin
         res_result  = s1_op[0];
      end else if (s1_inf[1]) begin
         res_result  = s1_op[1];
      end else if (&s1_zero) begin
         res_result  = {s1_op[0][WIDTH-1] & s1_op[1][WIDTH-1], {(WIDTH-1){1'b0}}};
      end else if (s1_zero[0]) begin
         res_result  = s1_op[1];
      end else if (s1_zero[1]) begin
         res_result  = s1_op[0];
      end else begin
         res_special = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid         <= 1'b0;
         out_special       <= 1'b0;
         out_result        <= '0;
         out_a             <= '0;
         out_b             <= '0;
         a_is_denormal     <= 1'b0;
         b_is_denormal     <= 1'b0;
         invalid_operation <= 1'b0;
      end else if (s2_load) begin
         out_valid         <= s1_valid;
         out_special       <= res_special;
         out_result        <= res_result;
         out_a             <= s1_op[0];
         out_b             <= s1_op[1];
         a_is_denormal     <= s1_den[0];
         b_is_denormal     <= s1_den[1];
         invalid_operation <= res_invalid;
      end
   end

   // A clear in the same cycle as a counted handshake wipes history, then records the new event.
   logic [CNT_W-1:0] cnt_base, cnt_next;

   always_comb begin
      cnt_base = flags_clr ? '0 : invalid_count;
      cnt_next = cnt_base;
      if (hs && invalid_operation && !(&cnt_base))
         cnt_next = cnt_base + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_invalid  <= 1'b0;
         sticky_denormal <= 1'b0;
         invalid_count   <= '0;
      end else begin
         sticky_invalid  <= (sticky_invalid & ~flags_clr) | (hs & invalid_operation);
         sticky_denormal <= (sticky_denormal & ~flags_clr) | (hs & (a_is_denormal | b_is_denormal));
         invalid_count   <= cnt_next;
      end
   end
endmodule

// File: tb/tb_fp_exception_pipe.sv
// Scoreboard bench for fp_exception_pipe: a reference model predicts each record at accept time,
// and a monitor pops and compares on every output handshake.
module tb_fp_exception_pipe;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, operation_select, out_valid, out_ready;
   logic          out_special, perform_operation, a_is_denormal, b_is_denormal;
   logic          invalid_operation, flags_clr, sticky_invalid, sticky_denormal;
   logic [31:0]   a, b, out_result, out_a, out_b;
   logic [CW-1:0] invalid_count;

   always #5 clk = ~clk;

   fp_exception_pipe #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .operation_select(operation_select), .out_valid(out_valid), .out_ready(out_ready),
      .out_special(out_special), .perform_operation(perform_operation), .out_result(out_result),
      .out_a(out_a), .out_b(out_b), .a_is_denormal(a_is_denormal), .b_is_denormal(b_is_denormal),
      .invalid_operation(invalid_operation), .flags_clr(flags_clr), .sticky_invalid(sticky_invalid),
      .sticky_denormal(sticky_denormal), .invalid_count(invalid_count));

   typedef struct {
      logic        special;
      logic [31:0] result;
      logic [31:0] oa;
      logic [31:0] ob;
      logic        aden;
      logic        bden;
      logic        inv;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0, miscompares = 0, pushed = 0, popped = 0, mcnt = 0;
   bit   stop_rand;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction
   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction
   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 0);
   endfunction
   function automatic logic is_den(input logic [31:0] x);
      return (x[30:23] == 8'h00) && (x[22:0] != 0);
   endfunction

   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic opv);
      exp_t        e;
      logic [31:0] x, y;
      x = av;
      y = {bv[31] ^ ~opv, bv[30:0]};
      e.aden = is_den(x);
      e.bden = is_den(y);
`ifdef FP_EXC_DENORMAL_FLUSH_EN
      if (e.aden) x = {x[31], 31'b0};
      if (e.bden) y = {y[31], 31'b0};
`endif
      e.special = 1'b1; e.inv = 1'b0; e.result = 32'h0; e.oa = x; e.ob = y;
      if (is_nan(x) || is_nan(y)) begin
         e.result = 32'h7FC00000;
         e.inv    = is_snan(x) || is_snan(y);
      end else if (is_inf(x) && is_inf(y) && (x[31] != y[31])) begin
         e.result = 32'h7FC00000;
         e.inv    = 1'b1;
      end else if (is_inf(x))                    e.result = x;
      else if (is_inf(y))                        e.result = y;
      else if (x[30:0] == 0 && y[30:0] == 0)     e.result = {x[31] & y[31], 31'b0};
      else if (x[30:0] == 0)                     e.result = y;
      else if (y[30:0] == 0)                     e.result = x;
      else                                       e.special = 1'b0;
      return e;
   endfunction

   // Monitor: the record visible at the negedge with out_ready high is taken at the next posedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got result %h with empty scoreboard, required none", out_result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            popped++;
            if (e.inv && mcnt < (2**CW - 1)) mcnt++;
            $display("rec %0d: special=%b result=%h out_a=%h out_b=%h inv=%b den=%b%b",
                     popped, out_special, out_result, out_a, out_b, invalid_operation,
                     a_is_denormal, b_is_denormal);
            if (out_special !== e.special || perform_operation !== !e.special ||
                out_result !== e.result || invalid_operation !== e.inv ||
                a_is_denormal !== e.aden || b_is_denormal !== e.bden ||
                (!e.special && (out_a !== e.oa || out_b !== e.ob))) begin
               miscompares++;
               $display("FAIL record_%0d: got sp=%b po=%b res=%h inv=%b den=%b%b a=%h b=%h, required sp=%b res=%h inv=%b den=%b%b a=%h b=%h",
                        popped, out_special, perform_operation, out_result, invalid_operation,
                        a_is_denormal, b_is_denormal, out_a, out_b, e.special, e.result, e.inv,
                        e.aden, e.bden, e.oa, e.ob);
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic opv);
      bit ok;
      ok = 1'b0;
      a = av; b = bv; operation_select = opv; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(model(av, bv, opv));
            pushed++;
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) break;
      end
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d records outstanding, required 0", sb_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; operation_select = 1'b1;
      out_ready = 1'b1; flags_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sticky_invalid !== 1'b0 ||
          sticky_denormal !== 1'b0 || invalid_count !== 0) begin
         miscompares++;
         $display("FAIL reset_state: got rdy=%b vld=%b si=%b sd=%b cnt=%0d, required 1 0 0 0 0",
                  in_ready, out_valid, sticky_invalid, sticky_denormal, invalid_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_inf_inf();
      send(32'h7F800000, 32'h7F800000, 1'b0);
      drain();
      vectors++;
      if (invalid_count !== 1 || sticky_invalid !== 1'b1) begin
         miscompares++;
         $display("FAIL infinf_flags: got cnt=%0d si=%b, required 1 1", invalid_count, sticky_invalid);
      end
   endtask

   task automatic test_nan();
      send(32'h7F800001, 32'h3F800000, 1'b1);
      drain();
      send(32'h7FC00000, 32'h3F800000, 1'b1);
      drain();
      vectors++;
      if (invalid_count !== 2) begin
         miscompares++;
         $display("FAIL nan_count: got %0d, required 2", invalid_count);
      end
   endtask

   task automatic test_zero();
      send(32'h80000000, 32'h00000000, 1'b0);
      drain();
      vectors++;
      if (sticky_denormal !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_sticky_den: got %b, required 0", sticky_denormal);
      end
   endtask

   task automatic test_ordinary_stall();
      out_ready = 1'b0;
      send(32'h3F800000, 32'h40000000, 1'b0);
      send(32'h40400000, 32'h3F800000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || perform_operation !== 1'b1 || out_special !== 1'b0 ||
             out_a !== 32'h3F800000 || out_b !== 32'hC0000000 || out_result !== 32'h0 ||
             in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold_%0d: got vld=%b po=%b a=%h b=%h res=%h rdy=%b, required 1 1 3f800000 c0000000 0 0",
                     i, out_valid, perform_operation, out_a, out_b, out_result, in_ready);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();
   endtask

   task automatic test_denormal();
      send(32'h00000001, 32'h3F800000, 1'b1);
      drain();
      vectors++;
      if (sticky_denormal !== 1'b1) begin
         miscompares++;
         $display("FAIL denormal_sticky: got %b, required 1", sticky_denormal);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 6; i++) send(32'hFF800123, 32'h40000000, 1'b1);
      drain();
      vectors++;
      if (invalid_count !== 3'd7) begin
         miscompares++;
         $display("FAIL count_saturate: got %0d, required 7", invalid_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pool [8];
      int start_pushed, start_popped;
      pool = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000,
               32'h7F800001, 32'h7FC00000, 32'h00000010, 32'h3F800000};
      start_pushed = pushed; start_popped = popped;
      stop_rand = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               logic [31:0] av, bv;
               av = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : $urandom;
               bv = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : $urandom;
               send(av, bv, 1'($urandom_range(0, 1)));
            end
            stop_rand = 1'b1;
         end
         begin
            while (!stop_rand) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      vectors++;
      if ((popped - start_popped) != 10 || (pushed - start_pushed) != 10) begin
         miscompares++;
         $display("FAIL stream_count: got %0d delivered of %0d sent, required 10 of 10",
                  popped - start_popped, pushed - start_pushed);
      end
      vectors++;
      if (invalid_count !== mcnt[CW-1:0]) begin
         miscompares++;
         $display("FAIL stream_inv_count: got %0d, required %0d", invalid_count, mcnt);
      end
   endtask

   task automatic test_clr_simul();
      out_ready = 1'b0;
      send(32'h7F800002, 32'h3F800000, 1'b1);
      @(posedge clk); #1;
      mcnt = 0;
      flags_clr = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      flags_clr = 1'b0;
      vectors++;
      if (invalid_count !== 1 || sticky_invalid !== 1'b1 || sticky_denormal !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_with_event: got cnt=%0d si=%b sd=%b, required 1 1 0",
                  invalid_count, sticky_invalid, sticky_denormal);
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      send(32'h00000001, 32'h7F800001, 1'b1);
      send(32'h3F800000, 32'h40000000, 1'b1);
      send(32'h7F800001, 32'h00000000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || invalid_count !== 0 || sticky_invalid !== 1'b0 ||
          sticky_denormal !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got vld=%b cnt=%0d si=%b sd=%b, required 0 0 0 0",
                  out_valid, invalid_count, sticky_invalid, sticky_denormal);
      end
      sb_q.delete();
      mcnt = 0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      send(32'h3F800000, 32'hC0000000, 1'b1);
      drain();
   endtask

   initial begin
      test_reset();
      test_inf_inf();
      test_nan();
      test_zero();
      test_ordinary_stall();
      test_denormal();
      test_saturation();
      test_back_to_back();
      test_clr_simul();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
